// File: rtl/lshifup_sync_bank.sv
// Multi-channel up-level-shifter bank: isolation clamp, N-stage synchroniser
// into the CLK domain and a per-channel deglitch filter driving registered Y
// plus a change-notify pulse.
module lshifup_sync_bank #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter bit          ISO_VAL     = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic             ISO,
  output logic [WIDTH-1:0] Y,
  output logic             CHG,
  output logic [WIDTH-1:0] CHG_MASK
);

  localparam int unsigned     CNT_W    = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [WIDTH-1:0] ISO_VEC  = {WIDTH{ISO_VAL}};

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("lshifup_sync_bank: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_chk_filt
    $error("lshifup_sync_bank: FILT_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             chg_q;

  // Clamp ahead of the first flop so a floating A is never captured.
  always_comb begin
    sync_in = ISO ? ISO_VEC : A;
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= ISO_VEC;
      end
    end else begin
      sync_q[0] <= sync_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Deglitch next-state: Y follows s only after FILT_CYCLES differing samples.
  always_comb begin
    y_d    = y_q;
    mask_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
    end
    if (ISO) begin
      // Forced clamp bypasses the filter but still reports the change.
      y_d    = ISO_VEC;
      mask_d = y_q ^ ISO_VEC;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] != y_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            y_d[i]    = s[i];
            mask_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Output and counter registers; reset suppresses any change report.
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q    <= ISO_VEC;
      mask_q <= '0;
      chg_q  <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      y_q    <= y_d;
      mask_q <= mask_d;
      chg_q  <= |mask_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign Y        = y_q;
  assign CHG      = chg_q;
  assign CHG_MASK = mask_q;

endmodule

// File: tb/tb_lshifup_sync_bank.sv
// Directed bench for lshifup_sync_bank: default configuration plus a
// WIDTH=1 / SYNC_STAGES=3 / FILT_CYCLES=1 instance.
module tb_lshifup_sync_bank;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       iso;
  logic [3:0] y;
  logic       chg;
  logic [3:0] chg_mask;

  logic       rst1;
  logic [0:0] a1;
  logic       iso1;
  logic [0:0] y1;
  logic       chg1;
  logic [0:0] mask1;

  int checks = 0;
  int errors = 0;

  lshifup_sync_bank #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .FILT_CYCLES(3),
    .ISO_VAL    (1'b0)
  ) u_dut (
    .CLK     (clk),
    .RST     (rst),
    .A       (a),
    .ISO     (iso),
    .Y       (y),
    .CHG     (chg),
    .CHG_MASK(chg_mask)
  );

  lshifup_sync_bank #(
    .WIDTH      (1),
    .SYNC_STAGES(3),
    .FILT_CYCLES(1),
    .ISO_VAL    (1'b0)
  ) u_dut1 (
    .CLK     (clk),
    .RST     (rst1),
    .A       (a1),
    .ISO     (iso1),
    .Y       (y1),
    .CHG     (chg1),
    .CHG_MASK(mask1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] ey, input logic ec,
                          input logic [3:0] em);
    step();
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".chg"}, 32'(chg), 32'(ec));
    check({tag, ".mask"}, 32'(chg_mask), 32'(em));
  endtask

  task automatic step_chk1(input string tag, input logic ey, input logic ec, input logic em);
    step();
    check({tag, ".y1"}, 32'(y1), 32'(ey));
    check({tag, ".chg1"}, 32'(chg1), 32'(ec));
    check({tag, ".mask1"}, 32'(mask1), 32'(em));
  endtask

  initial begin
    rst  = 1'b1;
    a    = 4'hF;
    iso  = 1'b0;
    rst1 = 1'b1;
    a1   = 1'b0;
    iso1 = 1'b0;
    #1;

    // 1: reset holds Y at ISO_VAL even with A high, then full latency to F.
    step();
    step_chk("rst", 4'h0, 1'b0, 4'h0);
    step_chk1("rst_p", 1'b0, 1'b0, 1'b0);
    rst  = 1'b0;
    rst1 = 1'b0;
    for (int e = 1; e <= 4; e++) step_chk("lat", 4'h0, 1'b0, 4'h0);
    step_chk("lat_e5", 4'hF, 1'b1, 4'hF);
    step_chk("lat_e6", 4'hF, 1'b0, 4'h0);

    // Return to Y=0 via reset with A low.
    rst = 1'b1;
    a   = 4'h0;
    step_chk("rst2", 4'h0, 1'b0, 4'h0);
    rst = 1'b0;
    step_chk("idle", 4'h0, 1'b0, 4'h0);

    // 2a: 2-cycle pulse on A[2] is rejected.
    a = 4'h4;
    step_chk("g2_e1", 4'h0, 1'b0, 4'h0);
    step_chk("g2_e2", 4'h0, 1'b0, 4'h0);
    a = 4'h0;
    for (int e = 3; e <= 8; e++) step_chk("g2", 4'h0, 1'b0, 4'h0);

    // 2b: 3-cycle pulse passes, rising at edge 5 and falling at edge 8.
    a = 4'h4;
    step_chk("g3_e1", 4'h0, 1'b0, 4'h0);
    step_chk("g3_e2", 4'h0, 1'b0, 4'h0);
    step_chk("g3_e3", 4'h0, 1'b0, 4'h0);
    a = 4'h0;
    step_chk("g3_e4", 4'h0, 1'b0, 4'h0);
    step_chk("g3_e5", 4'h4, 1'b1, 4'h4);
    step_chk("g3_e6", 4'h4, 1'b0, 4'h0);
    step_chk("g3_e7", 4'h4, 1'b0, 4'h0);
    step_chk("g3_e8", 4'h0, 1'b1, 4'h4);
    step_chk("g3_e9", 4'h0, 1'b0, 4'h0);

    // 3: bring Y to A, then isolate.
    a = 4'hA;
    for (int e = 1; e <= 4; e++) step_chk("toA", 4'h0, 1'b0, 4'h0);
    step_chk("toA_e5", 4'hA, 1'b1, 4'hA);
    step_chk("toA_e6", 4'hA, 1'b0, 4'h0);
    iso = 1'b1;
    step_chk("iso_e1", 4'h0, 1'b1, 4'hA);
    for (int e = 0; e < 8; e++) begin
      a = 4'($urandom_range(0, 15));
      step_chk("iso_hold", 4'h0, 1'b0, 4'h0);
    end

    // 4: release isolation with A=5.
    a   = 4'h5;
    iso = 1'b0;
    for (int e = 1; e <= 4; e++) step_chk("rel", 4'h0, 1'b0, 4'h0);
    step_chk("rel_e5", 4'h5, 1'b1, 4'h5);
    step_chk("rel_e6", 4'h5, 1'b0, 4'h0);

    // 5: reset in the middle of a 0->F transition.
    rst = 1'b1;
    a   = 4'h0;
    step_chk("rst5", 4'h0, 1'b0, 4'h0);
    rst = 1'b0;
    step_chk("rst5_idle", 4'h0, 1'b0, 4'h0);
    a = 4'hF;
    step_chk("mid_e1", 4'h0, 1'b0, 4'h0);
    step_chk("mid_e2", 4'h0, 1'b0, 4'h0);
    rst = 1'b1;
    step_chk("mid_e3_rst", 4'h0, 1'b0, 4'h0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) step_chk("post", 4'h0, 1'b0, 4'h0);
    step_chk("post_e5", 4'hF, 1'b1, 4'hF);
    step_chk("post_e6", 4'hF, 1'b0, 4'h0);

    // 6: SYNC_STAGES=3, FILT_CYCLES=1: latency 4, single-cycle pulse passes.
    a1 = 1'b1;
    step_chk1("p_e1", 1'b0, 1'b0, 1'b0);
    step_chk1("p_e2", 1'b0, 1'b0, 1'b0);
    step_chk1("p_e3", 1'b0, 1'b0, 1'b0);
    step_chk1("p_e4", 1'b1, 1'b1, 1'b1);
    step_chk1("p_e5", 1'b1, 1'b0, 1'b0);
    a1 = 1'b0;
    step_chk1("pp_e1", 1'b1, 1'b0, 1'b0);
    a1 = 1'b1;
    step_chk1("pp_e2", 1'b1, 1'b0, 1'b0);
    step_chk1("pp_e3", 1'b1, 1'b0, 1'b0);
    step_chk1("pp_e4", 1'b0, 1'b1, 1'b1);
    step_chk1("pp_e5", 1'b1, 1'b1, 1'b1);
    step_chk1("pp_e6", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
